// File: rtl/fan_pwm_ctrl.sv
// Fan controller: samples temperature, picks a speed level with hysteresis,
// ramps the PWM duty toward that level's target and drives the fan pin.
module fan_pwm_ctrl #(
    parameter int PWM_PERIOD = 1000,
    parameter int SAMPLE_DIV = 100000,
    parameter int THR_LOW    = 75,
    parameter int THR_MED    = 85,
    parameter int THR_HIGH   = 95,
    parameter int HYST       = 2,
    parameter int DUTY_LOW   = 400,
    parameter int DUTY_MED   = 700,
    parameter int RAMP_STEP  = 50
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [7:0]                        temp_f,
    input  logic                              enable,
    output logic                              pwm_out,
    output logic [1:0]                        speed_level,
    output logic [$clog2(PWM_PERIOD+1)-1:0]   duty
);
    localparam int DW  = $clog2(PWM_PERIOD + 1);
    localparam int SCW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int PCW = $clog2(PWM_PERIOD);

    typedef enum logic [1:0] {OFF = 2'd0, LOW = 2'd1, MED = 2'd2, HIGH = 2'd3} state_t;

    state_t          state, state_nx, up_lvl;
    logic [SCW-1:0]  sample_cnt;
    logic [PCW-1:0]  pwm_cnt;
    logic [7:0]      temp_q, eval_temp;
    logic [8:0]      t9, thr_cur;
    logic [DW-1:0]   target, duty_nx;
    logic            sample_edge, period_end;

    assign sample_edge = (sample_cnt == SCW'(SAMPLE_DIV - 1));
    assign period_end  = (pwm_cnt == PCW'(PWM_PERIOD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_cnt <= '0;
            pwm_cnt    <= '0;
            temp_q     <= '0;
        end else begin
            sample_cnt <= sample_edge ? '0 : sample_cnt + 1'b1;
            pwm_cnt    <= period_end ? '0 : pwm_cnt + 1'b1;
            if (sample_edge)
                temp_q <= temp_f;
        end
    end

    // Between samples the level flags see the held sample, so they only move on sample edges.
    assign eval_temp = sample_edge ? temp_f : temp_q;
    assign t9        = {1'b0, eval_temp};

    // FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= OFF;
        else        state <= state_nx;
    end

    // FSM: next state
    always_comb begin
        up_lvl = OFF;
        if      (t9 >= 9'(THR_HIGH)) up_lvl = HIGH;
        else if (t9 >= 9'(THR_MED))  up_lvl = MED;
        else if (t9 >= 9'(THR_LOW))  up_lvl = LOW;

        thr_cur = '0;
        case (state)
            LOW:     thr_cur = 9'(THR_LOW);
            MED:     thr_cur = 9'(THR_MED);
            HIGH:    thr_cur = 9'(THR_HIGH);
            default: thr_cur = '0;
        endcase

        state_nx = state;
        if (!enable) begin
            state_nx = OFF;
        end else if (sample_edge) begin
            if (up_lvl > state)
                state_nx = up_lvl;
            else if (state != OFF && (t9 + 9'(HYST)) < thr_cur)
                state_nx = state_t'(state - 2'd1);
        end
    end

    // FSM: outputs
    always_comb begin
        speed_level = state;
        case (state)
            LOW:     target = DW'(DUTY_LOW);
            MED:     target = DW'(DUTY_MED);
            HIGH:    target = DW'(PWM_PERIOD);
            default: target = '0;
        endcase
    end

    // Ramp toward target, clamped so it never crosses it.
    always_comb begin
        int d, t;
        d       = int'(duty);
        t       = int'(target);
        duty_nx = duty;
        if (d < t)
            duty_nx = (d + RAMP_STEP >= t) ? target : DW'(d + RAMP_STEP);
        else if (d > t)
            duty_nx = (d - RAMP_STEP <= t) ? target : DW'(d - RAMP_STEP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            duty    <= '0;
            pwm_out <= 1'b0;
        end else if (!enable) begin
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            if (period_end)
                duty <= duty_nx;
            pwm_out <= (DW'(pwm_cnt) < duty);
        end
    end
endmodule
